// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared constants and helpers for the gpu pixel writer
package painterengine_gpu_pkg;

  // Controller state encoding, kept as plain constants for legacy tooling
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One 32-bit pixel per word address
  localparam int unsigned DEFAULT_ADDR_STRIDE = 4;

  // Next write address; wraps naturally modulo 2^32
  function automatic logic [31:0] advance_addr(input logic [31:0] addr, input int unsigned stride);
    return addr + stride;
  endfunction

endpackage

// File: rtl/painterengine_gpu_sync_fifo.sv
// rtl/painterengine_gpu_sync_fifo.sv - synchronous fifo with registered first-word output
module painterengine_gpu_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      remain;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             push_ok, pop_ok;

  // Count includes the entry mirrored in the output register; full is judged
  // before any pop so a full fifo never accepts, even on a simultaneous pop.
  assign push_ok = push_i && (count_q != FULL_LEVEL);
  assign pop_ok  = pop_i && dout_valid_q;

  assign full_o  = (count_q == FULL_LEVEL);
  assign empty_o = !dout_valid_q;
  assign data_o  = dout_q;
  assign count_o = count_q;

  // Pointer/count bookkeeping and prefetch of the head entry into the output register
  always_comb begin
    wr_ptr_d     = wr_ptr_q + AW'(push_ok);
    rd_ptr_d     = rd_ptr_q + AW'(pop_ok);
    count_d      = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    remain       = count_q - (AW+1)'(pop_ok);
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    // Only entries written before this edge are eligible; a word pushed into an
    // empty fifo reaches the output register one cycle later.
    if (!dout_valid_q || pop_ok) begin
      dout_valid_d = (remain != '0);
      dout_d       = mem_q[rd_ptr_d];
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/painterengine_gpu_pixel_writer.sv
// rtl/painterengine_gpu_pixel_writer.sv - buffers blender pixels and writes them to memory per job
module painterengine_gpu_pixel_writer
  import painterengine_gpu_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          STALL_MARGIN = 4,
  parameter int unsigned ADDR_STRIDE  = DEFAULT_ADDR_STRIDE
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_reset,
  input  logic        i_wire_start,
  input  logic [31:0] i_wire_base_addr,
  input  logic [31:0] i_wire_pixel_count,
  input  logic [31:0] i_wire_data_in,
  input  logic        i_wire_data_valid,
  output logic        o_wire_stall,
  output logic [31:0] o_wire_mem_addr,
  output logic [31:0] o_wire_mem_data,
  output logic        o_wire_mem_valid,
  input  logic        i_wire_mem_ready,
  output logic        o_wire_busy,
  output logic        o_wire_done,
  output logic        o_wire_overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] STALL_LEVEL = CW'(FIFO_DEPTH - STALL_MARGIN);

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   accepted_q, accepted_d;
  logic [31:0]   written_q, written_d;
  logic          overflow_q, overflow_d;
  logic          stall_q, stall_d;

  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] occ_next;
  logic [31:0]   fifo_dout;
  logic          in_run, wanted, push, drop, pop, last_beat;

  painterengine_gpu_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (i_wire_clock),
    .rst_i   (i_wire_reset),
    .push_i  (push),
    .data_i  (i_wire_data_in),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Pixels count only in RUN and only up to the programmed total; a wanted
  // pixel that meets a full fifo is lost and flagged.
  assign in_run    = (state_q == ST_RUN);
  assign wanted    = in_run && i_wire_data_valid && (accepted_q < count_q);
  assign push      = wanted && !fifo_full;
  assign drop      = wanted && fifo_full;
  assign pop       = !fifo_empty && i_wire_mem_ready;
  assign last_beat = in_run && pop && ((written_q + 32'd1) == count_q);

  // Occupancy after this edge, so the registered stall tracks current fill level
  assign occ_next = fifo_count + CW'(push) - CW'(pop);

  assign o_wire_mem_valid = !fifo_empty;
  assign o_wire_mem_addr  = addr_q;
  assign o_wire_mem_data  = fifo_dout;
  assign o_wire_busy      = (state_q == ST_RUN);
  assign o_wire_done      = (state_q == ST_DONE);
  assign o_wire_overflow  = overflow_q;
  assign o_wire_stall     = stall_q;

  // Job sequencing, counters and write address
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    overflow_d = overflow_q;
    stall_d    = (occ_next >= STALL_LEVEL);
    case (state_q)
      ST_IDLE: begin
        if (i_wire_start) begin
          addr_d     = i_wire_base_addr;
          count_d    = i_wire_pixel_count;
          accepted_d = '0;
          written_d  = '0;
          overflow_d = 1'b0;
          state_d    = (i_wire_pixel_count == 32'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (push) begin
          accepted_d = accepted_q + 32'd1;
        end
        if (drop) begin
          overflow_d = 1'b1;
        end
        if (pop) begin
          addr_d    = advance_addr(addr_q, ADDR_STRIDE);
          written_d = written_q + 32'd1;
        end
        if (last_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register update; reset abandons any job in flight
  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
      overflow_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
      overflow_q <= overflow_d;
      stall_q    <= stall_d;
    end
  end

endmodule
